nibble_capture: RTL and testbench
=================================

NIBBLE_CAPTURE -- requirements
Module: nibble_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive cycles the synchronised button must hold a level before that level is accepted; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 sw  input  4  raw switch nibble; asynchronous to clk.
REQ-005 btn  input  1  raw load push-button; asynchronous to clk; bouncy.
REQ-006 out  output  4  last captured nibble; feeds the downstream 4-bit code-conversion stage's `in`.
REQ-007 valid  output  1  one-cycle strobe marking a new value on out.
REQ-008 count  output  4  number of captures since reset, modulo 16.

Function
REQ-009 sw and btn SHALL each pass through a two-flop synchroniser (sw_s, btn_s); no other logic SHALL use raw sw or btn.
REQ-010 The FSM SHALL have exactly four states: IDLE, PRESS, HELD and RELEASE, plus a debounce counter cnt of width clog2(DEBOUNCE_CYCLES)+1.
REQ-011 IDLE: btn_s=1 -> PRESS with cnt=1; otherwise stay in IDLE with cnt=0.
REQ-012 PRESS: btn_s=0 -> IDLE with cnt=0; btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD plus capture; otherwise cnt+1.
REQ-013 Capture SHALL, on the same edge, load out<=sw_s, set valid<=1 and set count<=count+1.
REQ-014 HELD: btn_s=0 -> RELEASE with cnt=1; otherwise stay in HELD; no further capture while the button stays held.
REQ-015 RELEASE: btn_s=1 -> HELD with cnt=0 and no capture; btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE with cnt=0; otherwise cnt+1.
REQ-016 valid SHALL be 1 for exactly one cycle per capture and 0 in every other cycle.
REQ-017 Latency: with btn held high from the first sampling edge E0, valid SHALL be high in the cycle after edge E(DEBOUNCE_CYCLES+1).
REQ-018 Any btn_s low glitch in PRESS SHALL restart qualification from IDLE; any btn_s high glitch in RELEASE SHALL return to HELD; neither case SHALL produce a capture.
REQ-019 out SHALL hold its value between captures, whatever sw does.
REQ-020 count SHALL wrap from 15 to 0 on the 16th capture, with no other side effect.
REQ-021 A sw change in the same cycle as capture SHALL NOT be captured; out takes the sw_s value present at that edge.

Reset
REQ-022 While rst=1 at a rising edge: state=IDLE, cnt=0, out=4'b0000, valid=0, count=0, and both synchroniser chains cleared to 0.
REQ-023 rst SHALL override every transition, including a capture edge; no valid pulse SHALL occur in the reset cycle or the cycle after it.
REQ-024 rst asserted mid-PRESS or mid-HELD SHALL abandon the operation; after rst falls with btn still high, a full qualification (REQ-017) SHALL be required before the next capture.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 rst for 2 cycles, then sw=12 and btn=1 held for 10 cycles -> out=12, valid high in exactly one cycle (after edge E5), count=1.
REQ-026 sw=10, btn toggled 1,0,1,0 on alternate cycles, then held high -> no valid pulse during the toggling; exactly one capture with out=10 after the stable hold.
REQ-027 Press and release 16 times with sw=4, each release lasting at least 6 cycles -> 16 valid pulses, out=4, count=0 after the last capture.
REQ-028 btn held high for 50 cycles -> a single valid pulse; changing sw to 9 during HELD leaves out unchanged.
REQ-029 rst pulsed for 1 cycle in PRESS with cnt=2 and btn still high -> out=0 and count=0; the capture occurs only 6 edges after rst deasserts.
REQ-030 In RELEASE with cnt=2, a 1-cycle btn high glitch -> return to HELD with no pulse; a subsequent press requires a full release of 4 cycles first.

Source files
------------

// File: rtl/nibble_capture.sv
// Debounced switch-nibble capture: a qualified press of btn loads sw into out,
// pulses valid for one cycle and advances a modulo-16 capture count.
module nibble_capture #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn,
  output logic [3:0] out,
  output logic       valid,
  output logic [3:0] count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  logic [3:0]    r_sw_meta;
  logic [3:0]    r_sw_s;
  logic          r_btn_meta;
  logic          r_btn_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_out;
  logic          r_valid;
  logic [3:0]    r_count;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_capture;

  // Two-flop synchronisers; nothing downstream touches the raw inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_meta  <= 4'b0000;
      r_sw_s     <= 4'b0000;
      r_btn_meta <= 1'b0;
      r_btn_s    <= 1'b0;
    end else begin
      r_sw_meta  <= sw;
      r_sw_s     <= r_sw_meta;
      r_btn_meta <= btn;
      r_btn_s    <= r_btn_meta;
    end
  end

  // Debounce FSM state and qualification counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; a capture fires only on the PRESS->HELD transition.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_btn_s) begin
          w_state_nxt = PRESS;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      PRESS: begin
        if (!r_btn_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = CNT_ZERO;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = PRESS;
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!r_btn_s) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = HELD;
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      RELEASE: begin
        // A high glitch while releasing goes straight back to HELD without capturing.
        if (r_btn_s) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Capture register, one-cycle strobe and wrapping capture count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= 4'b0000;
      r_valid <= 1'b0;
      r_count <= 4'b0000;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_out   <= r_sw_s;
        r_count <= r_count + 4'd1;
      end else begin
        r_out   <= r_out;
        r_count <= r_count;
      end
    end
  end

  assign out   = r_out;
  assign valid = r_valid;
  assign count = r_count;

endmodule

// File: tb/tb_nibble_capture.sv
// Self-checking bench for nibble_capture: directed vector table, corner-case
// sequences and randomized stimulus against a run-length reference model.
module tb_nibble_capture;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic       btn;
  logic [3:0] out;
  logic       valid;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  nibble_capture #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .btn   (btn),
    .out   (out),
    .valid (valid),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a 2-edge input delay, then button runs measured in cycles.
  logic       m_b1, m_b2;
  logic [3:0] m_s1, m_s2;
  int         m_ones, m_zeros;
  bit         m_held;
  logic [3:0] m_out;
  logic       m_valid;
  int         m_count;

  task automatic model_reset();
    m_b1 = 1'b0; m_b2 = 1'b0; m_s1 = 4'd0; m_s2 = 4'd0;
    m_ones = 0; m_zeros = 0; m_held = 0;
    m_out = 4'd0; m_valid = 1'b0; m_count = 0;
  endtask

  task automatic model_step(input logic r, input logic [3:0] s, input logic b);
    logic       bs;
    logic [3:0] ss;
    if (r) begin
      model_reset();
    end else begin
      bs = m_b2;
      ss = m_s2;
      m_b2 = m_b1; m_b1 = b;
      m_s2 = m_s1; m_s1 = s;
      if (bs) begin
        m_ones++;
        m_zeros = 0;
      end else begin
        m_zeros++;
        m_ones = 0;
      end
      m_valid = 1'b0;
      if (!m_held && bs && m_ones == D) begin
        m_held  = 1;
        m_out   = ss;
        m_valid = 1'b1;
        m_count = (m_count + 1) % 16;
      end else if (m_held && !bs && m_zeros == D) begin
        m_held = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] s, input logic b);
    @(negedge clk);
    rst = r; sw = s; btn = b;
    @(posedge clk);
    model_step(r, s, b);
    #1;
    if (valid === 1'b1) pulses++;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out"},   {4'b0000, out},   {4'b0000, m_out});
    check({tag, ".valid"}, {7'b0, valid},    {7'b0, m_valid});
    check({tag, ".count"}, {4'b0000, count}, 8'(m_count));
  endtask

  task automatic run(input logic r, input logic [3:0] s, input logic b, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      apply(r, s, b);
      check_model(tag);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] sw;
    logic       btn;
    logic [3:0] e_out;
    logic       e_valid;
    logic [3:0] e_count;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int first;
    logic       rb;
    logic       rr;
    logic [3:0] rs;

    rst = 1'b1; sw = 4'd0; btn = 1'b0;
    model_reset();

    // Two reset cycles, then sw=12 with btn held: capture lands after edge E5.
    vecs[0]  = '{1'b1, 4'd0,  1'b0, 4'd0,  1'b0, 4'd0};
    vecs[1]  = '{1'b1, 4'd0,  1'b0, 4'd0,  1'b0, 4'd0};
    vecs[2]  = '{1'b0, 4'd12, 1'b1, 4'd0,  1'b0, 4'd0};
    vecs[3]  = '{1'b0, 4'd12, 1'b1, 4'd0,  1'b0, 4'd0};
    vecs[4]  = '{1'b0, 4'd12, 1'b1, 4'd0,  1'b0, 4'd0};
    vecs[5]  = '{1'b0, 4'd12, 1'b1, 4'd0,  1'b0, 4'd0};
    vecs[6]  = '{1'b0, 4'd12, 1'b1, 4'd0,  1'b0, 4'd0};
    vecs[7]  = '{1'b0, 4'd12, 1'b1, 4'd12, 1'b1, 4'd1};
    vecs[8]  = '{1'b0, 4'd12, 1'b1, 4'd12, 1'b0, 4'd1};
    vecs[9]  = '{1'b0, 4'd12, 1'b1, 4'd12, 1'b0, 4'd1};
    vecs[10] = '{1'b0, 4'd12, 1'b1, 4'd12, 1'b0, 4'd1};
    vecs[11] = '{1'b0, 4'd12, 1'b1, 4'd12, 1'b0, 4'd1};

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].rst, vecs[i].sw, vecs[i].btn);
      check($sformatf("vec%0d.out", i),   {4'b0000, out},   {4'b0000, vecs[i].e_out});
      check($sformatf("vec%0d.valid", i), {7'b0, valid},    {7'b0, vecs[i].e_valid});
      check($sformatf("vec%0d.count", i), {4'b0000, count}, {4'b0000, vecs[i].e_count});
    end

    // Toggling button never qualifies; the stable hold that follows captures once.
    run(1'b0, 4'd10, 1'b0, 8, "rel26");
    pulses = 0;
    run(1'b0, 4'd10, 1'b1, 1, "tog");
    run(1'b0, 4'd10, 1'b0, 1, "tog");
    run(1'b0, 4'd10, 1'b1, 1, "tog");
    run(1'b0, 4'd10, 1'b0, 1, "tog");
    check("toggle_no_pulse", 8'(pulses), 8'd0);
    run(1'b0, 4'd10, 1'b1, 10, "hold26");
    check("toggle_then_hold_pulses", 8'(pulses), 8'd1);
    check("toggle_then_hold_out", {4'b0000, out}, 8'd10);

    // Long hold: one pulse, sw changes while held are ignored.
    run(1'b0, 4'd3, 1'b0, 8, "rel28");
    pulses = 0;
    run(1'b0, 4'd3, 1'b1, 20, "hold28");
    run(1'b0, 4'd9, 1'b1, 30, "hold28sw");
    check("long_hold_pulses", 8'(pulses), 8'd1);
    check("long_hold_out", {4'b0000, out}, 8'd3);

    // High glitch during release returns to HELD; a full release is then required.
    pulses = 0;
    run(1'b0, 4'd5, 1'b0, 2, "rel30");
    run(1'b0, 4'd5, 1'b1, 1, "glitch30");
    run(1'b0, 4'd5, 1'b0, 3, "short30");
    run(1'b0, 4'd5, 1'b1, 8, "press30");
    check("release_glitch_no_pulse", 8'(pulses), 8'd0);
    run(1'b0, 4'd5, 1'b0, 6, "full30");
    run(1'b0, 4'd5, 1'b1, 8, "press30b");
    check("after_full_release_pulse", 8'(pulses), 8'd1);
    check("after_full_release_out", {4'b0000, out}, 8'd5);

    // Reset mid-PRESS with btn still high: capture only 6 edges after reset falls.
    run(1'b1, 4'd0, 1'b0, 2, "rst29");
    run(1'b0, 4'd7, 1'b1, 4, "press29");
    apply(1'b1, 4'd7, 1'b1);
    check_model("rstpulse");
    check("rst_mid_press_out", {4'b0000, out}, 8'd0);
    check("rst_mid_press_count", {4'b0000, count}, 8'd0);
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      apply(1'b0, 4'd7, 1'b1);
      check_model("requal");
      if (valid === 1'b1 && first == 0) first = k;
    end
    check("requal_latency", 8'(first), 8'd6);

    // Sixteen press/release cycles from reset wrap count back to zero.
    run(1'b1, 4'd4, 1'b0, 2, "rst27");
    pulses = 0;
    for (int n = 0; n < 16; n++) begin
      run(1'b0, 4'd4, 1'b1, 8, "p27");
      run(1'b0, 4'd4, 1'b0, 8, "r27");
    end
    check("wrap_pulses", 8'(pulses), 8'd16);
    check("wrap_out", {4'b0000, out}, 8'd4);
    check("wrap_count", {4'b0000, count}, 8'd0);

    // Randomized bouncy button, changing switches and occasional reset.
    rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      rr = ($urandom_range(0, 199) == 0);
      rs = 4'($urandom_range(0, 15));
      apply(rr, rs, rb);
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
